multicycle_main_control: RTL and testbench



---
 rtl/multicycle_main_control_pkg.sv | 122 ++++++++++++
 rtl/multicycle_main_control_if.sv | 37 +++
 rtl/multicycle_main_control_mem_watchdog.sv | 41 ++++
 rtl/multicycle_main_control.sv | 129 ++++++++++++
 tb/tb_multicycle_main_control.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_main_control_pkg.sv
// Shared types and encodings for the multicycle main control FSM:
// state enumeration, opcode/aluOp/mux encodings and the per-state strobe decode.
package control_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned ALUOP_W  = 3;
    localparam int unsigned SEL_W    = 2;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_R   = 4'd3,
        ST_WB_R     = 4'd4,
        ST_EXEC_I   = 4'd5,
        ST_WB_I     = 4'd6,
        ST_MEM_ADDR = 4'd7,
        ST_MEM_RD   = 4'd8,
        ST_WB_MEM   = 4'd9,
        ST_MEM_WR   = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12
    } state_e;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 3'b000;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b001;
    localparam logic [ALUOP_W-1:0] ALUOP_SLT   = 3'b010;
    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b011;

    localparam logic [SEL_W-1:0] SRCB_RT      = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    // Moore strobe set; 'fetch' marks the state whose irWrite/pcWrite follow memReady.
    typedef struct packed {
        logic               fetch;
        logic               pc_write;
        logic               pc_write_cond;
        logic               ior_d;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               reg_dst;
        logic               reg_write;
        logic               alu_src_a;
        logic [SEL_W-1:0]   alu_src_b;
        logic [SEL_W-1:0]   pc_source;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input state_e st, input logic [OPCODE_W-1:0] op);
        ctrl_t c;
        c           = '0;
        c.alu_op    = ALUOP_ADD;
        c.alu_src_b = SRCB_RT;
        c.pc_source = PCSRC_ALU;
        case (st)
            ST_FETCH: begin
                c.fetch     = 1'b1;
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
            end
            ST_DECODE: c.alu_src_b = SRCB_IMM_SH2;
            ST_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALUOP_RTYPE;
            end
            ST_WB_R: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            ST_EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = (op == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
            end
            ST_WB_I: c.reg_write = 1'b1;
            ST_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            ST_MEM_RD: begin
                c.mem_read = 1'b1;
                c.ior_d    = 1'b1;
            end
            ST_WB_MEM: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            ST_MEM_WR: begin
                c.mem_write = 1'b1;
                c.ior_d     = 1'b1;
            end
            ST_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALUOP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_JUMP;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_main_control_if.sv
// Controller <-> datapath/memory signal bundle. master = controller side.
interface multicycle_main_control_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       opcode;
    logic             memReady;
    logic             pcWrite;
    logic             pcWriteCond;
    logic             iorD;
    logic             memRead;
    logic             memWrite;
    logic             irWrite;
    logic             memToReg;
    logic             regDst;
    logic             regWrite;
    logic             aluSrcA;
    logic [1:0]       aluSrcB;
    logic [1:0]       pcSource;
    logic [2:0]       aluOp;
    logic             illegalOp;
    logic             memFault;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, memReady,
        output pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
               memToReg, regDst, regWrite, aluSrcA, aluSrcB, pcSource,
               aluOp, illegalOp, memFault, retired
    );

    modport slave (
        output opcode, memReady,
        input  pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
               memToReg, regDst, regWrite, aluSrcA, aluSrcB, pcSource,
               aluOp, illegalOp, memFault, retired
    );
endinterface

// File: rtl/multicycle_main_control_mem_watchdog.sv
// Memory wait watchdog: counts un-acknowledged request cycles and latches a
// sticky fault when the limit is hit without memReady.
module mem_watchdog #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_active,
    input  logic mem_ready,
    output logic timeout_c,
    output logic mem_fault
);
    localparam int unsigned     WD_W  = 8;
    localparam logic [WD_W-1:0] LIMIT = WD_W'(MEM_TIMEOUT - 1);

    logic [WD_W-1:0] cnt_q, cnt_d;
    logic            fault_q, fault_d;

    // memReady in the limit cycle completes the transfer, so it suppresses the timeout.
    always_comb begin
        timeout_c = req_active && !mem_ready && (cnt_q == LIMIT);
        cnt_d     = cnt_q + WD_W'(1);
        if (!req_active || mem_ready || timeout_c) begin
            cnt_d = '0;
        end
        fault_d   = fault_q | timeout_c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    assign mem_fault = fault_q;

endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle main control: fetch/decode/execute/memory/writeback sequencer with
// memory handshake, watchdog fault and retired-instruction counter.
module multicycle_main_control
    import control_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    multicycle_main_control_if.master  bus
);

    state_e                state_q, state_d;
    logic [OPCODE_W-1:0]   opcode_q, opcode_d;
    ctrl_t                 ctrl_q, ctrl_d;
    logic                  illegal_op_q, illegal_op_d;
    logic [CNT_W-1:0]      retired_q, retired_d;
    logic                  retire_c;
    logic                  mem_wait_c;
    logic                  timeout_c;
    logic                  mem_fault;

    assign mem_wait_c = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) ||
                        (state_q == ST_MEM_WR);

    mem_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_watchdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_active (mem_wait_c),
        .mem_ready  (bus.memReady),
        .timeout_c  (timeout_c),
        .mem_fault  (mem_fault)
    );

    // Next state, opcode capture, retire detection and next-cycle strobes.
    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        illegal_op_d = 1'b0;
        retire_c     = 1'b0;
        case (state_q)
            ST_IDLE: state_d = mem_fault ? ST_IDLE : ST_FETCH;
            ST_FETCH: begin
                if (timeout_c) begin
                    state_d = ST_IDLE;
                end else if (bus.memReady) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                opcode_d = bus.opcode;
                case (bus.opcode)
                    OP_RTYPE:        state_d = ST_EXEC_R;
                    OP_LW, OP_SW:    state_d = ST_MEM_ADDR;
                    OP_ADDI, OP_SLTI: state_d = ST_EXEC_I;
                    OP_BEQ:          state_d = ST_BRANCH;
                    OP_J:            state_d = ST_JUMP;
                    default: begin
                        state_d      = ST_FETCH;
                        illegal_op_d = 1'b1;
                    end
                endcase
            end
            ST_EXEC_R:   state_d = ST_WB_R;
            ST_EXEC_I:   state_d = ST_WB_I;
            ST_MEM_ADDR: state_d = (opcode_q == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: begin
                if (timeout_c) begin
                    state_d = ST_IDLE;
                end else if (bus.memReady) begin
                    state_d = ST_WB_MEM;
                end
            end
            ST_MEM_WR: begin
                if (timeout_c) begin
                    state_d = ST_IDLE;
                end else if (bus.memReady) begin
                    state_d  = ST_FETCH;
                    retire_c = 1'b1;
                end
            end
            ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP: begin
                state_d  = ST_FETCH;
                retire_c = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        retired_d = retire_c ? (retired_q + CNT_W'(1)) : retired_q;
        ctrl_d    = decode_ctrl(state_d, opcode_d);
    end

    // Strobes are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            opcode_q     <= OP_RTYPE;
            ctrl_q       <= decode_ctrl(ST_IDLE, OP_RTYPE);
            illegal_op_q <= 1'b0;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            ctrl_q       <= ctrl_d;
            illegal_op_q <= illegal_op_d;
            retired_q    <= retired_d;
        end
    end

    assign bus.irWrite     = ctrl_q.fetch & bus.memReady;
    assign bus.pcWrite     = ctrl_q.pc_write | (ctrl_q.fetch & bus.memReady);
    assign bus.pcWriteCond = ctrl_q.pc_write_cond;
    assign bus.iorD        = ctrl_q.ior_d;
    assign bus.memRead     = ctrl_q.mem_read;
    assign bus.memWrite    = ctrl_q.mem_write;
    assign bus.memToReg    = ctrl_q.mem_to_reg;
    assign bus.regDst      = ctrl_q.reg_dst;
    assign bus.regWrite    = ctrl_q.reg_write;
    assign bus.aluSrcA     = ctrl_q.alu_src_a;
    assign bus.aluSrcB     = ctrl_q.alu_src_b;
    assign bus.pcSource    = ctrl_q.pc_source;
    assign bus.aluOp       = ctrl_q.alu_op;
    assign bus.illegalOp   = illegal_op_q;
    assign bus.memFault    = mem_fault;
    assign bus.retired     = retired_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: instruction recipes build a
// per-cycle expectation queue that one negedge process compares against the DUT.
module tb_multicycle_main_control;

    localparam int unsigned TB_CNT_W   = 4;
    localparam int unsigned TB_TIMEOUT = 4;

    localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC_R = 3, P_WB_R = 4,
                   P_EXEC_I = 5, P_WB_I = 6, P_MEM_ADDR = 7, P_MEM_RD = 8,
                   P_WB_MEM = 9, P_MEM_WR = 10, P_BRANCH = 11, P_JUMP = 12;

    localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011,
                           T_ADDI = 6'b001000, T_SLTI = 6'b001010,
                           T_BEQ = 6'b000100, T_J = 6'b000010, T_BAD = 6'b111111;

    typedef struct packed {
        logic                pcWrite;
        logic                pcWriteCond;
        logic                iorD;
        logic                memRead;
        logic                memWrite;
        logic                irWrite;
        logic                memToReg;
        logic                regDst;
        logic                regWrite;
        logic                aluSrcA;
        logic [1:0]          aluSrcB;
        logic [1:0]          pcSource;
        logic [2:0]          aluOp;
        logic                illegalOp;
        logic                memFault;
        logic [TB_CNT_W-1:0] retired;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    multicycle_main_control_if #(.CNT_W(TB_CNT_W)) bus ();

    multicycle_main_control #(
        .MEM_TIMEOUT (TB_TIMEOUT),
        .CNT_W       (TB_CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   ph_q[$];
    exp_t cmp_e, cmp_g;
    int   cmp_ph;

    int   m_retired;
    bit   m_fault;
    bit   m_illegal_next;

    // Output table for each phase of an instruction.
    function automatic exp_t phase_out(input int ph, input bit rdy, input logic [5:0] op);
        exp_t e;
        e       = '0;
        e.aluOp = 3'b011;
        case (ph)
            P_FETCH:    begin e.memRead = 1; e.aluSrcB = 2'b01; e.irWrite = rdy; e.pcWrite = rdy; end
            P_DECODE:   e.aluSrcB = 2'b11;
            P_EXEC_R:   begin e.aluSrcA = 1; e.aluOp = 3'b000; end
            P_WB_R:     begin e.regDst = 1; e.regWrite = 1; end
            P_EXEC_I:   begin e.aluSrcA = 1; e.aluSrcB = 2'b10; e.aluOp = (op == T_SLTI) ? 3'b010 : 3'b011; end
            P_WB_I:     e.regWrite = 1;
            P_MEM_ADDR: begin e.aluSrcA = 1; e.aluSrcB = 2'b10; end
            P_MEM_RD:   begin e.memRead = 1; e.iorD = 1; end
            P_WB_MEM:   begin e.memToReg = 1; e.regWrite = 1; end
            P_MEM_WR:   begin e.memWrite = 1; e.iorD = 1; end
            P_BRANCH:   begin e.aluSrcA = 1; e.aluOp = 3'b001; e.pcWriteCond = 1; e.pcSource = 2'b01; end
            P_JUMP:     begin e.pcWrite = 1; e.pcSource = 2'b10; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic exp_t got_now();
        exp_t g;
        g.pcWrite     = bus.pcWrite;
        g.pcWriteCond = bus.pcWriteCond;
        g.iorD        = bus.iorD;
        g.memRead     = bus.memRead;
        g.memWrite    = bus.memWrite;
        g.irWrite     = bus.irWrite;
        g.memToReg    = bus.memToReg;
        g.regDst      = bus.regDst;
        g.regWrite    = bus.regWrite;
        g.aluSrcA     = bus.aluSrcA;
        g.aluSrcB     = bus.aluSrcB;
        g.pcSource    = bus.pcSource;
        g.aluOp       = bus.aluOp;
        g.illegalOp   = bus.illegalOp;
        g.memFault    = bus.memFault;
        g.retired     = bus.retired;
        return g;
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {T_R, T_LW, T_SW, T_ADDI, T_SLTI, T_BEQ, T_J};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cmp_e  = exp_q.pop_front();
            cmp_ph = ph_q.pop_front();
            cmp_g  = got_now();
            n_checks++;
            if (cmp_g !== cmp_e) begin
                n_errors++;
                $display("FAIL outputs cycle %0d phase %0d: got %b required %b",
                         cyc, cmp_ph, cmp_g, cmp_e);
            end
        end
        cyc++;
    end

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    task automatic clear_model();
        m_retired      = 0;
        m_fault        = 1'b0;
        m_illegal_next = 1'b0;
    endtask

    // One clock: drive inputs just after the edge and queue this cycle's expectation.
    task automatic step(input int ph, input bit rdy, input logic [5:0] drv_op,
                        input logic [5:0] lat_op, input bit rst_v);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n        = rst_v;
        bus.memReady = rdy;
        bus.opcode   = drv_op;
        e            = phase_out(ph, rdy, lat_op);
        e.illegalOp  = m_illegal_next;
        e.memFault   = m_fault;
        e.retired    = TB_CNT_W'(m_retired);
        m_illegal_next = 1'b0;
        exp_q.push_back(e);
        ph_q.push_back(ph);
    endtask

    // A memory phase waiting nwait cycles; ok=0 if it faulted or was aborted by reset.
    task automatic wait_phase(input int ph, input int nwait, input logic [5:0] drv,
                              input logic [5:0] lat, input bit abort, output bit ok);
        ok = 1'b1;
        for (int i = 0; i < nwait && i < int'(TB_TIMEOUT); i++) begin
            if (abort && i == 1) begin
                step(ph, 1'b0, drv, lat, 1'b0);
                clear_model();
                step(P_IDLE, 1'b0, drv, lat, 1'b1);
                ok = 1'b0;
                return;
            end
            step(ph, 1'b0, drv, lat, 1'b1);
        end
        if (nwait >= int'(TB_TIMEOUT)) begin
            m_fault = 1'b1;
            step(P_IDLE, 1'b1, drv, lat, 1'b1);
            step(P_IDLE, 1'b1, drv, lat, 1'b1);
            ok = 1'b0;
            return;
        end
        step(ph, 1'b1, drv, lat, 1'b1);
    endtask

    task automatic do_instr(input logic [5:0] op, input int fwait, input int mwait, input bit abort);
        logic [5:0] junk;
        bit         ok;
        junk = op ^ 6'b101010;
        wait_phase(P_FETCH, fwait, junk, junk, 1'b0, ok);
        if (!ok) return;
        step(P_DECODE, 1'b1, op, op, 1'b1);
        if (!is_legal(op)) begin
            m_illegal_next = 1'b1;
            return;
        end
        case (op)
            T_R: begin
                step(P_EXEC_R, 1'b1, junk, op, 1'b1);
                step(P_WB_R, 1'b1, junk, op, 1'b1);
            end
            T_ADDI, T_SLTI: begin
                step(P_EXEC_I, 1'b1, junk, op, 1'b1);
                step(P_WB_I, 1'b1, junk, op, 1'b1);
            end
            T_LW: begin
                step(P_MEM_ADDR, 1'b1, junk, op, 1'b1);
                wait_phase(P_MEM_RD, mwait, junk, op, 1'b0, ok);
                if (!ok) return;
                step(P_WB_MEM, 1'b1, junk, op, 1'b1);
            end
            T_SW: begin
                step(P_MEM_ADDR, 1'b1, junk, op, 1'b1);
                wait_phase(P_MEM_WR, mwait, junk, op, abort, ok);
                if (!ok) return;
            end
            T_BEQ: step(P_BRANCH, 1'b1, junk, op, 1'b1);
            default: step(P_JUMP, 1'b1, junk, op, 1'b1);
        endcase
        m_retired++;
    endtask

    // One FETCH wait cycle, then park at mid-cycle for literal checks.
    task automatic fetch_peek();
        step(P_FETCH, 1'b0, T_BAD, T_BAD, 1'b1);
        @(negedge clk);
    endtask

    task automatic reset_from_idle();
        step(P_IDLE, 1'b0, T_R, T_R, 1'b0);
        clear_model();
        step(P_IDLE, 1'b0, T_R, T_R, 1'b1);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.memReady = 1'b0;
        bus.opcode   = T_R;
        clear_model();
        @(posedge clk);
        step(P_IDLE, 1'b0, T_R, T_R, 1'b1);
        @(negedge clk);
        lit("reset_retired", 32'(bus.retired), 32'd0);
        lit("reset_memFault", 32'(bus.memFault), 32'd0);
        lit("reset_aluOp", 32'(bus.aluOp), 32'd3);
        lit("reset_memRead", 32'(bus.memRead), 32'd0);

        do_instr(T_R, 1, 0, 1'b0);
        fetch_peek();
        lit("rtype_retired", 32'(bus.retired), 32'd1);

        do_instr(T_LW, 0, 3, 1'b0);
        do_instr(T_SW, 2, 1, 1'b0);
        do_instr(T_BEQ, 0, 0, 1'b0);
        do_instr(T_J, 1, 0, 1'b0);
        do_instr(T_SLTI, 0, 0, 1'b0);
        do_instr(T_ADDI, 3, 0, 1'b0);

        do_instr(T_BAD, 0, 0, 1'b0);
        fetch_peek();
        lit("illegal_pulse", 32'(bus.illegalOp), 32'd1);
        lit("illegal_retired", 32'(bus.retired), 32'd7);
        do_instr(T_R, 0, 0, 1'b0);
        do_instr(T_LW, 1, 3, 1'b0);

        do_instr(T_R, 4, 0, 1'b0);
        @(negedge clk);
        lit("fetch_timeout_fault", 32'(bus.memFault), 32'd1);
        lit("fetch_timeout_memRead", 32'(bus.memRead), 32'd0);
        lit("fetch_timeout_retired", 32'(bus.retired), 32'd9);
        reset_from_idle();

        do_instr(T_LW, 0, 4, 1'b0);
        @(negedge clk);
        lit("memrd_timeout_fault", 32'(bus.memFault), 32'd1);
        reset_from_idle();

        do_instr(T_R, 0, 0, 1'b0);
        do_instr(T_BEQ, 0, 0, 1'b0);
        do_instr(T_SW, 0, 3, 1'b1);
        @(negedge clk);
        lit("abort_memWrite", 32'(bus.memWrite), 32'd0);
        lit("abort_retired", 32'(bus.retired), 32'd0);

        for (int i = 0; i < 15; i++) do_instr(T_J, 0, 0, 1'b0);
        fetch_peek();
        lit("wrap_pre_retired", 32'(bus.retired), 32'd15);
        do_instr(T_J, 0, 0, 1'b0);
        fetch_peek();
        lit("wrap_retired", 32'(bus.retired), 32'd0);
        do_instr(T_R, 0, 0, 1'b0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
